seg_decoder: RTL and testbench
==============================

SEG_DECODER -- requirements
Module: seg_decoder

Purpose: recovers character codes from a 7-segment drive bus (the segment encoding used by the display encoder), e.g. for on-board self-check of display output.

Interface
- Parameters:
  - REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, range 1..255: consecutive identical samples required before a pattern is accepted.
- Ports:
  - REQ-002 The block SHALL have `clk`, input, 1 bit: single clock; all state changes on its rising edge.
  - REQ-003 The block SHALL have `reset`, input, 1 bit: synchronous, active-high reset.
  - REQ-004 The block SHALL have `led`, input, 8 bits: bit7 = decimal point and bits6:0 = segments g..a, all active-low (0 = lit).
  - REQ-005 The block SHALL have `alpha`, input, 1 bit: selects letter decoding for ambiguous patterns when 1 and hex decoding when 0.
  - REQ-006 The block SHALL have `out_valid`, output, 1 bit: a decoded character is presented.
  - REQ-007 The block SHALL have `out_ready`, input, 1 bit: the consumer accepts the presented character.
  - REQ-008 The block SHALL have `value`, output, 8 bits: decoded character code.
  - REQ-009 The block SHALL have `known`, output, 1 bit: the pattern matched the decode table.
  - REQ-010 The block SHALL have `dp`, output, 1 bit: decimal point lit (inverse of the sampled led[7]).
  - REQ-011 The block SHALL have `err_count`, output, 8 bits: unknown-pattern count (see Configuration).

Function
- REQ-012 The block SHALL keep candidate register `cand`[7:0] and stability counter `cnt`[7:0], updated every cycle.
- REQ-013 When led differs from cand in any of its 8 bits, the block SHALL load cand with led and set cnt to 0; otherwise it SHALL increment cnt, saturating at STABLE_CYCLES-1.
- REQ-014 A pattern SHALL be stable once cnt == STABLE_CYCLES-1 with led == cand in the same cycle.
- REQ-015 The FSM SHALL have exactly two states, TRACK and EMIT; out_valid SHALL be 1 only in EMIT.
- REQ-016 TRACK->EMIT SHALL occur when a pattern is stable and either no character has been emitted since reset or cand differs from the last accepted pattern. The block SHALL latch value, known and dp on this transition, so out_valid rises on the cycle after the STABLE_CYCLES-th identical sample.
- REQ-017 EMIT->TRACK SHALL occur on a cycle with out_valid && out_ready; the block SHALL then record the emitted cand as the last accepted pattern.
- REQ-018 While in EMIT, value, known and dp SHALL stay constant regardless of led changes; cand/cnt tracking SHALL continue.
- REQ-019 After acceptance, a pattern already stable SHALL be emitted on the following cycle if it differs from the last accepted pattern; patterns that appeared and vanished while in EMIT SHALL be lost.
- REQ-020 The block SHALL decode unambiguous patterns independent of `alpha`, using led[6:0]:
  - 1111111->127
  - 0100100->2
  - 0110000->3
  - 0011001->4
  - 0000010->6
  - 1111000->7
  - 0000000->8
  - 0010000->9
  - 0000011->11
  - 0000110->14
  - 0001110->15
  - 1001000->78 (N)
  - 0001100->80 (P)
  - 0000111->84 (T)
  - 0001001->88 (X)
- REQ-021 The block SHALL decode ambiguous patterns as hex when alpha=0 and as a letter when alpha=1:
  - 1000000->0/79 (O)
  - 1111001->1/73 (I)
  - 0010010->5/83 (S)
  - 0001000->10/65 (A)
  - 1000110->12/67 (C)
  - 0100001->13/68 (d)
- REQ-022 The block SHALL sample `alpha` on the TRACK->EMIT cycle.
- REQ-023 Any other pattern SHALL yield value=8'hFF and known=0; all table hits SHALL yield known=1.
- REQ-024 A dp change alone SHALL count as a new pattern and re-emit the same value with the updated dp.
- REQ-025 With STABLE_CYCLES=1, a pattern SHALL be emittable on the first cycle it appears.

Reset
- REQ-026 While reset=1 the block SHALL force the FSM to TRACK, out_valid=0, value=0, known=0, dp=0, cand=8'hFF, cnt=0 and the no-pattern-emitted-yet flag to set.
- REQ-027 Reset asserted in EMIT SHALL drop out_valid on the next edge and discard the pending character.
- REQ-028 err_count SHALL reset to 0 when enabled.

Configuration
- REQ-029 With macro SEG_DECODER_ERRCNT_EN defined, err_count SHALL increment by 1 on each accepted (out_valid && out_ready) character with known=0, saturating at 255.
- REQ-030 With SEG_DECODER_ERRCNT_EN undefined, err_count SHALL be tied to 0, the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (STABLE_CYCLES=4 unless stated)
- REQ-031 The bench SHALL cover: reset, then hold led=8'hFF with out_ready=1 -> out_valid first rises 4 cycles after reset release with value=127, known=1, dp=0, and is emitted exactly once.
- REQ-032 The bench SHALL cover: led=8'hC0 (dp off, "0") held 10 cycles, alpha=0 then repeated with alpha=1 after an intervening 8'hFF -> value=0 then value=79.
- REQ-033 The bench SHALL cover: led toggles 8'hA4/8'hB0 every 2 cycles for 20 cycles -> no out_valid; then 8'hB0 held 4 cycles -> value=3.
- REQ-034 The bench SHALL cover: out_ready=0 while "2" is emitted, led changes to 8'h99 ("4") stably for 6 cycles -> value stays 2; out_ready=1 -> 2 accepted, value=4 presented the next cycle.
- REQ-035 The bench SHALL cover: led=8'h7F (pattern 1111111, dp lit) -> dp=1, value=127; then 8'h55 stable -> value=8'hFF, known=0, and err_count=1 after acceptance when SEG_DECODER_ERRCNT_EN is defined, 0 otherwise.
- REQ-036 The bench SHALL cover: reset pulsed for 1 cycle while out_valid=1 -> out_valid=0 on the next edge, and no character is emitted until 4 stable samples follow.

Source files
------------

// File: rtl/seg_decoder.sv
// seg_decoder: recovers character codes from an active-low 7-segment drive
// bus (bit7 = decimal point, bits 6:0 = segments g..a).
// A pattern must be seen STABLE_CYCLES times in a row before it is decoded.
// The result is then presented with a valid/ready handshake.
// Optional feature: define SEG_DECODER_ERRCNT_EN to count accepted characters
// that did not match the decode table (saturating at 255). When the macro is
// not defined, err_count is tied to 0.
//
// state | meaning
// TRACK | watching led for a stable pattern that is new
// EMIT  | presenting a latched character, waiting for out_ready
module seg_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] led,
    input  logic       alpha,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] value,
    output logic       known,
    output logic       dp,
    output logic [7:0] err_count
);

    typedef enum logic {
        TRACK = 1'b0,
        EMIT  = 1'b1
    } state_t;

    localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
    // With a single required sample the live bus is trusted immediately,
    // so a pattern can be emitted on the first cycle it appears.
    localparam bit ONE_SHOT = (STABLE_CYCLES == 1);

    state_t     state_q, state_d;
    logic [7:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] value_q, value_d;
    logic       known_q, known_d;
    logic       dp_q, dp_d;
    logic       first_q, first_d;
    logic [7:0] last_q, last_d;
    logic [7:0] emit_q, emit_d;

    logic [7:0] dec_value;
    logic       dec_known;
    logic       stable;
    logic       new_pat;

    // Table lookup on the live segment bits; alpha picks letters for shapes
    // that are also hex digits.
    always_comb begin
        dec_value = 8'hFF;
        dec_known = 1'b1;
        case (led[6:0])
            7'b1111111: dec_value = 8'd127;
            7'b0100100: dec_value = 8'd2;
            7'b0110000: dec_value = 8'd3;
            7'b0011001: dec_value = 8'd4;
            7'b0000010: dec_value = 8'd6;
            7'b1111000: dec_value = 8'd7;
            7'b0000000: dec_value = 8'd8;
            7'b0010000: dec_value = 8'd9;
            7'b0000011: dec_value = 8'd11;
            7'b0000110: dec_value = 8'd14;
            7'b0001110: dec_value = 8'd15;
            7'b1001000: dec_value = 8'd78;
            7'b0001100: dec_value = 8'd80;
            7'b0000111: dec_value = 8'd84;
            7'b0001001: dec_value = 8'd88;
            7'b1000000: dec_value = alpha ? 8'd79 : 8'd0;
            7'b1111001: dec_value = alpha ? 8'd73 : 8'd1;
            7'b0010010: dec_value = alpha ? 8'd83 : 8'd5;
            7'b0001000: dec_value = alpha ? 8'd65 : 8'd10;
            7'b1000110: dec_value = alpha ? 8'd67 : 8'd12;
            7'b0100001: dec_value = alpha ? 8'd68 : 8'd13;
            default: begin
                dec_value = 8'hFF;
                dec_known = 1'b0;
            end
        endcase
    end

    // Next-state: candidate/stability tracking plus the TRACK/EMIT handshake.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        known_d = known_q;
        dp_d    = dp_q;
        first_d = first_q;
        last_d  = last_q;
        emit_d  = emit_q;

        if (led != cand_q) begin
            cand_d = led;
            cnt_d  = 8'd0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 8'd1;
        end

        stable  = ONE_SHOT | ((led == cand_q) && (cnt_q == CNT_MAX));
        new_pat = first_q | (led != last_q);

        case (state_q)
            TRACK: begin
                if (stable && new_pat) begin
                    state_d = EMIT;
                    value_d = dec_value;
                    known_d = dec_known;
                    dp_d    = ~led[7];
                    emit_d  = led;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = TRACK;
                    last_d  = emit_q;
                    first_d = 1'b0;
                end
            end
            default: state_d = TRACK;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= TRACK;
            cand_q  <= 8'hFF;
            cnt_q   <= 8'd0;
            value_q <= 8'd0;
            known_q <= 1'b0;
            dp_q    <= 1'b0;
            first_q <= 1'b1;
            last_q  <= 8'hFF;
            emit_q  <= 8'hFF;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            known_q <= known_d;
            dp_q    <= dp_d;
            first_q <= first_d;
            last_q  <= last_d;
            emit_q  <= emit_d;
        end
    end

    assign out_valid = (state_q == EMIT);
    assign value     = value_q;
    assign known     = known_q;
    assign dp        = dp_q;

`ifdef SEG_DECODER_ERRCNT_EN
    logic [7:0] err_q;

    // Count unknown characters as they are handed over, stopping at 255.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 8'd0;
        end else if ((state_q == EMIT) && out_ready && !known_q && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

    assign err_count = err_q;
`else
    assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_seg_decoder.sv
// Directed bench for seg_decoder with STABLE_CYCLES = 4.
module tb_seg_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] led;
    logic       alpha;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] value;
    logic       known;
    logic       dp;
    logic [7:0] err_count;

    int vectors;
    int miscompares;
    bit seen;
    int hits;

    seg_decoder #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .led       (led),
        .alpha     (alpha),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .value     (value),
        .known     (known),
        .dp        (dp),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic count_valid(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset     = 1'b1;
        led       = 8'hFF;
        alpha     = 1'b0;
        out_ready = 1'b1;
        step(2);
        check("rst_valid", {7'b0, out_valid}, 8'd0);
        check("rst_value", value, 8'd0);
        check("rst_known", {7'b0, known}, 8'd0);
        check("rst_dp", {7'b0, dp}, 8'd0);
        check("rst_err", err_count, 8'd0);

        // blank display held from reset: emits 127 four edges after release
        reset = 1'b0;
        step(3);
        check("blank_early", {7'b0, out_valid}, 8'd0);
        step(1);
        check("blank_valid", {7'b0, out_valid}, 8'd1);
        check("blank_value", value, 8'd127);
        check("blank_known", {7'b0, known}, 8'd1);
        check("blank_dp", {7'b0, dp}, 8'd0);
        count_valid(8, hits);
        check("blank_once", hits[7:0], 8'd0);

        // "0" as hex, then as letter O after an intervening blank
        led = 8'hC0;
        wait_valid(10, seen);
        check("zero_seen", {7'b0, seen}, 8'd1);
        check("zero_value", value, 8'd0);
        check("zero_known", {7'b0, known}, 8'd1);
        count_valid(5, hits);
        check("zero_once", hits[7:0], 8'd0);
        led = 8'hFF;
        wait_valid(10, seen);
        check("blank2_value", value, 8'd127);
        step(1);
        alpha = 1'b1;
        led   = 8'hC0;
        wait_valid(10, seen);
        check("o_seen", {7'b0, seen}, 8'd1);
        check("o_value", value, 8'd79);
        step(1);

        // toggling pattern never settles, then "3" held
        alpha = 1'b0;
        hits  = 0;
        for (int k = 0; k < 10; k++) begin
            led = (k % 2 == 0) ? 8'hA4 : 8'hB0;
            repeat (2) begin
                @(negedge clk);
                if (out_valid) hits++;
            end
        end
        check("toggle_quiet", hits[7:0], 8'd0);
        led = 8'hB0;
        wait_valid(8, seen);
        check("three_seen", {7'b0, seen}, 8'd1);
        check("three_value", value, 8'd3);
        step(1);

        // back-pressure: "2" held while "4" settles underneath
        out_ready = 1'b0;
        led       = 8'hA4;
        wait_valid(10, seen);
        check("two_value", value, 8'd2);
        led = 8'h99;
        step(6);
        check("bp_valid", {7'b0, out_valid}, 8'd1);
        check("bp_value", value, 8'd2);
        out_ready = 1'b1;
        step(1);
        check("bp_accept", {7'b0, out_valid}, 8'd0);
        step(1);
        check("four_valid", {7'b0, out_valid}, 8'd1);
        check("four_value", value, 8'd4);
        step(1);

        // decimal point lit, then an unknown pattern
        led = 8'h7F;
        wait_valid(10, seen);
        check("dp_value", value, 8'd127);
        check("dp_lit", {7'b0, dp}, 8'd1);
        step(1);
        led = 8'h55;
        wait_valid(10, seen);
        check("unk_value", value, 8'hFF);
        check("unk_known", {7'b0, known}, 8'd0);
        step(1);
`ifdef SEG_DECODER_ERRCNT_EN
        check("unk_err", err_count, 8'd1);
`else
        check("unk_err", err_count, 8'd0);
`endif

        // a decimal-point change alone re-emits the same digit
        led = 8'hA4;
        wait_valid(10, seen);
        check("dpchg_a_value", value, 8'd2);
        check("dpchg_a_dp", {7'b0, dp}, 8'd0);
        step(1);
        led = 8'h24;
        wait_valid(10, seen);
        check("dpchg_b_seen", {7'b0, seen}, 8'd1);
        check("dpchg_b_value", value, 8'd2);
        check("dpchg_b_dp", {7'b0, dp}, 8'd1);
        step(1);

        // alpha is captured at emission; later alpha changes are ignored
        out_ready = 1'b0;
        alpha     = 1'b1;
        led       = 8'h88;
        wait_valid(10, seen);
        check("a_value", value, 8'd65);
        alpha = 1'b0;
        step(2);
        check("a_hold", value, 8'd65);
        out_ready = 1'b1;
        step(1);

        // reset pulse while a character is pending
        out_ready = 1'b0;
        led       = 8'hC6;
        wait_valid(10, seen);
        check("c_value", value, 8'd12);
        reset = 1'b1;
        step(1);
        check("rstp_valid", {7'b0, out_valid}, 8'd0);
        check("rstp_value", value, 8'd0);
        reset = 1'b0;
        count_valid(4, hits);
        check("rstp_quiet", hits[7:0], 8'd0);
        wait_valid(3, seen);
        check("rstp_seen", {7'b0, seen}, 8'd1);
        check("rstp_c_value", value, 8'd12);
        out_ready = 1'b1;
        step(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
